image_mem_pixel_reader: RTL and testbench
=========================================

Name: image_mem_pixel_reader

Overview:
- Read-side streamer for the image processing pipeline.
- Acts as an Avalon-MM read master into the single-port 32-bit on-chip image memory, which has a fixed read latency of one cycle.
- Unpacks each 32-bit word into four 8-bit grayscale pixels and emits them on an Avalon-ST source with ready/valid backpressure and packet framing.
- The local Nios core starts one job (base word address plus pixel count) per image region.

Parameters:
ADDR_W, 17, word address width of the on-chip memory
DATA_W, 32, memory data width; fixed at 4 pixels per word
PIX_W, 8, pixel width
MAX_WORDS, 125000, memory depth in words, used for bounds checking
CNT_W, 19, pixel count width (covers 4*MAX_WORDS = 500000)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle job request; sampled only in IDLE
base_addr  in  ADDR_W  first word address, latched on accepted start
num_pixels  in  CNT_W  pixel count, latched on accepted start
busy  out  1  job in progress
done  out  1  one-cycle pulse after the final pixel is accepted
error  out  1  one-cycle pulse when a start is rejected
m_address  out  ADDR_W  memory word address
m_chipselect  out  1  read strobe; one word per asserted cycle
m_write  out  1  tied 0
m_byteenable  out  4  tied 4'hF
m_clken  out  1  tied 1
m_readdata  in  DATA_W  valid in the cycle after m_chipselect
src_data  out  PIX_W  pixel
src_valid  out  1  pixel valid
src_ready  in  1  sink accepts when src_valid and src_ready are both high
src_sop  out  1  marks the first pixel of the job
src_eop  out  1  marks the last pixel of the job

Behaviour:
- Reset values: busy, done, error, m_chipselect, src_valid, src_sop and src_eop are 0; m_address and src_data are 0. FIFO, counters and FSM are cleared.
- Reset mid-job: abort. All outputs take their reset values in the next cycle and any in-flight read data is discarded.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE + start: words = ceil(num_pixels/4).
  - Reject when num_pixels==0 or base_addr+words > MAX_WORDS: error pulses the next cycle, no read is issued, stay in IDLE.
  - Otherwise latch the job and go to RUN; busy=1 from the next cycle.
  - RUN: issue reads at consecutive addresses. When the last read has been issued, go to DRAIN.
  - DRAIN: emit the remaining pixels. When the eop handshake completes, go to DONE.
  - DONE: done=1 and busy=0 for one cycle, then IDLE.
  - start outside IDLE is ignored.
- Read issue rule: m_chipselect=1 only if (words in FIFO + reads in flight) < 2.
- Read data capture: m_readdata is captured unconditionally into a 2-entry word FIFO in the cycle after the read strobe. With this credit limit the FIFO can never overflow.
- No address wrap-around is possible; the start-time bounds check guarantees it.
- Latency: start accepted in cycle 0, first m_chipselect in cycle 1, data captured at the end of cycle 2, first src_valid in cycle 3.
- Throughput: one pixel per cycle while src_ready=1; steady state is one read per 4 pixels.
- Unpack order is little-endian: bits [7:0] first, then [15:8], [23:16], [31:24].
- Partial last word (num_pixels mod 4 != 0): emit only the remaining low bytes, then drop the word.
- src_sop is high with pixel 0 only. src_eop is high with pixel num_pixels-1 only. A 1-pixel job has sop and eop high together.
- While src_valid=1 and src_ready=0, src_data, src_sop and src_eop are held stable.
- Pixel counter decrements on each handshake; src_valid never asserts after the eop handshake.

Decomposition:
- Package image_stream_pkg holds:
  - ADDR_W, PIX_W, MAX_WORDS, CNT_W
  - PIX_PER_WORD=4
  - the FSM state enum {IDLE, RUN, DRAIN, DONE}
- Sub-module word_fifo2: a 2-entry synchronous FIFO with push, pop, count and head data. It is reusable by the planned write-side packer.

Test Plan:
- Basic job: mem[0]=0x44332211, mem[1]=0x88776655, base=0, num_pixels=8, src_ready=1.
  - Pixels 11..88 appear on 8 consecutive cycles starting in cycle 3; sop on 11, eop on 88.
  - Exactly 2 chipselects, at addresses 0 and 1; done one cycle after the eop handshake.
- Partial word: same memory contents, num_pixels=6.
  - Output 11,22,33,44,55,66 with eop on 66.
  - 2 reads issued; bytes 77/88 are never emitted.
- Backpressure: num_pixels=16, src_ready random at 50%.
  - Output sequence is identical to the ready=1 run.
  - Data is stable while stalled; FIFO count + reads in flight never exceeds 2.
- Rejected starts: num_pixels=0, or base=124999 with num_pixels=8.
  - error pulses once, m_chipselect stays 0, busy stays 0.
- Reset mid-job: reset asserted after 3 handshakes.
  - Next cycle: busy=0, src_valid=0, m_chipselect=0.
  - A new start with base=1, num_pixels=4 yields 55,66,77,88, with sop on 55.
- start during busy is ignored; a start issued in the cycle after done runs a full second job correctly.

Source files
------------

// File: rtl/image_stream_pkg.sv
// Shared constants, FSM state type and helpers for the image streaming blocks.
package image_stream_pkg;

  localparam int ADDR_W       = 17;
  localparam int DATA_W       = 32;
  localparam int PIX_W        = 8;
  localparam int MAX_WORDS    = 125000;
  localparam int CNT_W        = 19;
  localparam int PIX_PER_WORD = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  // Number of memory words needed to hold n pixels (rounded up).
  function automatic logic [CNT_W-1:0] words_for(input logic [CNT_W-1:0] n);
    logic [CNT_W:0] t;
    t = {1'b0, n} + (CNT_W+1)'(PIX_PER_WORD - 1);
    return {1'b0, t[CNT_W:2]};
  endfunction

endpackage

// File: rtl/image_mem_pixel_reader_if.sv
// Memory read bus (Avalon-MM) and pixel stream (Avalon-ST) of the pixel reader.
interface image_mem_pixel_reader_if;
  import image_stream_pkg::*;

  logic [ADDR_W-1:0] m_address;
  logic              m_chipselect;
  logic              m_write;
  logic [3:0]        m_byteenable;
  logic              m_clken;
  logic [DATA_W-1:0] m_readdata;

  logic [PIX_W-1:0]  src_data;
  logic              src_valid;
  logic              src_ready;
  logic              src_sop;
  logic              src_eop;

  modport master (
    output m_address, m_chipselect, m_write, m_byteenable, m_clken,
    input  m_readdata,
    output src_data, src_valid, src_sop, src_eop,
    input  src_ready
  );

  modport slave (
    input  m_address, m_chipselect, m_write, m_byteenable, m_clken,
    output m_readdata,
    input  src_data, src_valid, src_sop, src_eop,
    output src_ready
  );

endinterface

// File: rtl/word_fifo2.sv
// Two-entry synchronous word FIFO with head-of-queue data and occupancy count.
module word_fifo2 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [1:0]       count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             pop_ok;
  logic             push_ok;

  assign pop_ok  = pop && (count != 2'd0);
  assign push_ok = push && ((count != 2'd2) || pop_ok);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) wr_ptr <= ~wr_ptr;
      if (pop_ok)  rd_ptr <= ~rd_ptr;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; the count guards every read,
    // so stale contents are never observed and the array maps to plain flops/RAM.
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/image_mem_pixel_reader.sv
// Reads words from the on-chip image memory and streams them out as 8-bit
// pixels, low byte first, with sop/eop framing and ready/valid backpressure.
module image_mem_pixel_reader
  import image_stream_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [CNT_W-1:0]      num_pixels,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  image_mem_pixel_reader_if.master bus
);

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  words_left;
  logic [CNT_W-1:0]  pix_left;
  logic [1:0]        byte_idx;
  logic              sop_pending;
  logic              in_flight;
  logic              error_q;

  logic [CNT_W-1:0]  req_words;
  logic [CNT_W:0]    req_end;
  logic              req_reject;
  logic              accept;
  logic              issue;
  logic              pix_valid;
  logic              hs;
  logic              last_pix;
  logic              pop;
  logic [1:0]        fifo_count;
  logic [DATA_W-1:0] fifo_head;

  // Job request evaluation: word count and memory bounds check.
  always_comb begin
    req_words  = words_for(num_pixels);
    req_end    = (CNT_W+1)'(base_addr) + {1'b0, req_words};
    req_reject = (num_pixels == '0) || (req_end > (CNT_W+1)'(MAX_WORDS));
    accept     = (state == IDLE) && start && !req_reject;
  end

  // Read issue is credit-limited so buffered plus in-flight words never exceed two.
  assign issue     = (state == RUN) && (words_left != '0) &&
                     ((fifo_count + 2'(in_flight)) < 2'd2);
  assign pix_valid = ((state == RUN) || (state == DRAIN)) &&
                     (fifo_count != 2'd0) && (pix_left != '0);
  assign hs        = pix_valid && bus.src_ready;
  assign last_pix  = (pix_left == CNT_W'(1));
  assign pop       = hs && ((byte_idx == 2'd3) || last_pix);

  word_fifo2 #(.WIDTH(DATA_W)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (in_flight),
    .push_data (bus.m_readdata),
    .pop       (pop),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // FSM next-state logic.
  always_comb begin
    // NOTE: default first so every path assigns state_nx and no latch is inferred.
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (issue && (words_left == CNT_W'(1))) state_nx = DRAIN;
      DRAIN:   if (hs && last_pix) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Job datapath: read address, remaining words/pixels, byte lane, framing.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q      <= '0;
      words_left  <= '0;
      pix_left    <= '0;
      byte_idx    <= 2'd0;
      sop_pending <= 1'b0;
      in_flight   <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      in_flight <= issue;
      error_q   <= (state == IDLE) && start && req_reject;
      if (accept) begin
        addr_q      <= base_addr;
        words_left  <= req_words;
        pix_left    <= num_pixels;
        byte_idx    <= 2'd0;
        sop_pending <= 1'b1;
      end else begin
        if (issue) begin
          addr_q     <= addr_q + ADDR_W'(1);
          words_left <= words_left - CNT_W'(1);
        end
        if (hs) begin
          pix_left    <= pix_left - CNT_W'(1);
          byte_idx    <= byte_idx + 2'd1;
          sop_pending <= 1'b0;
        end
      end
    end
  end

  assign busy  = (state == RUN) || (state == DRAIN);
  assign done  = (state == DONE);
  assign error = error_q;

  assign bus.m_address    = addr_q;
  assign bus.m_chipselect = issue;
  assign bus.m_write      = 1'b0;
  assign bus.m_byteenable = 4'hF;
  assign bus.m_clken      = 1'b1;

  assign bus.src_valid = pix_valid;
  assign bus.src_data  = pix_valid ? fifo_head[{byte_idx, 3'b000} +: PIX_W] : '0;
  assign bus.src_sop   = pix_valid && sop_pending;
  assign bus.src_eop   = pix_valid && last_pix;

endmodule

// File: tb/tb_image_mem_pixel_reader.sv
// Self-checking bench: scoreboard of expected pixels and read addresses,
// memory model with one-cycle read latency, directed job sequence.
module tb_image_mem_pixel_reader;
  import image_stream_pkg::*;

  typedef struct {
    logic [7:0] data;
    logic       sop;
    logic       eop;
    logic       wlast;
  } pix_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  num_pixels;
  logic              busy;
  logic              done;
  logic              error;

  image_mem_pixel_reader_if bus ();

  image_mem_pixel_reader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .num_pixels (num_pixels),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .bus        (bus.master)
  );

  always #5 clk = ~clk;

  logic [31:0]       mem [16];
  pix_t              exp_q [$];
  logic [ADDR_W-1:0] addr_q [$];

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  bit rand_ready = 1'b0;

  int c0, first_cs, first_val, last_val, eop_cyc;
  int cs_cnt, hs_cnt, err_cnt, busy_cnt, outstanding;
  bit stall_prev;
  logic [9:0] prev_out;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    tests++;
    assert (obs === req) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, req);
    end
  endtask

  // Memory model: registered read, data valid the cycle after chipselect.
  always @(posedge clk) begin
    if (bus.m_chipselect) bus.m_readdata <= mem[bus.m_address[3:0]];
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    bus.src_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Output monitor: scoreboard compare, stall stability, read credit.
  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (busy)  busy_cnt++;
      if (error) err_cnt++;
      check("credit", 32'((outstanding + int'(bus.m_chipselect)) <= 2), 32'd1);
      if (stall_prev) begin
        check("stall_valid", 32'(bus.src_valid), 32'd1);
        check("stall_hold", 32'({bus.src_data, bus.src_sop, bus.src_eop}), 32'(prev_out));
      end
      if (bus.m_chipselect) begin
        cs_cnt++;
        outstanding++;
        if (first_cs < 0) first_cs = cyc;
        check("extra_read", 32'(addr_q.size() != 0), 32'd1);
        if (addr_q.size() != 0) check("read_addr", 32'(bus.m_address), 32'(addr_q.pop_front()));
      end
      if (bus.src_valid && bus.src_ready) begin
        hs_cnt++;
        if (first_val < 0) first_val = cyc;
        last_val = cyc;
        check("extra_pixel", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          pix_t e;
          e = exp_q.pop_front();
          check("pixel", 32'({bus.src_data, bus.src_sop, bus.src_eop}),
                32'({e.data, e.sop, e.eop}));
          if (e.eop) eop_cyc = cyc;
          if (e.wlast) outstanding--;
        end
      end
      stall_prev = bus.src_valid && !bus.src_ready;
      prev_out   = {bus.src_data, bus.src_sop, bus.src_eop};
    end
  end

  task automatic clear_stats();
    c0 = cyc; first_cs = -1; first_val = -1; last_val = -1; eop_cyc = -1;
    cs_cnt = 0; hs_cnt = 0; err_cnt = 0; busy_cnt = 0;
  endtask

  // Start an accepted job and push its expected pixels and read addresses.
  task automatic start_job(input logic [ADDR_W-1:0] base, input int n);
    @(posedge clk); #1;
    start = 1'b1; base_addr = base; num_pixels = CNT_W'(n);
    clear_stats();
    for (int i = 0; i < n; i++) begin
      pix_t e;
      logic [31:0] w;
      w = mem[4'(int'(base) + i / 4)];
      e.data  = w[8 * (i % 4) +: 8];
      e.sop   = (i == 0);
      e.eop   = (i == n - 1);
      e.wlast = (i % 4 == 3) || (i == n - 1);
      exp_q.push_back(e);
    end
    for (int k = 0; k < (n + 3) / 4; k++) addr_q.push_back(base + ADDR_W'(k));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Wait (bounded) for done, then check framing, latency and completeness.
  task automatic finish_job(input string tag, input int n, input bit contiguous);
    int done_cyc;
    done_cyc = -1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (done) begin
        done_cyc = cyc;
        break;
      end
    end
    check({tag, "_done_seen"}, 32'(done_cyc >= 0), 32'd1);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "_pixels_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_reads_left"}, 32'(addr_q.size()), 32'd0);
    check({tag, "_read_count"}, 32'(cs_cnt), 32'((n + 3) / 4));
    check({tag, "_handshakes"}, 32'(hs_cnt), 32'(n));
    check({tag, "_first_cs_cycle"}, 32'(first_cs), 32'(c0 + 1));
    check({tag, "_done_after_eop"}, 32'(done_cyc), 32'(eop_cyc + 1));
    check({tag, "_no_error"}, 32'(err_cnt), 32'd0);
    if (contiguous) begin
      check({tag, "_first_valid_cycle"}, 32'(first_val), 32'(c0 + 3));
      check({tag, "_consecutive"}, 32'(last_val - first_val), 32'(n - 1));
    end
  endtask

  task automatic reject_job(input string tag, input logic [ADDR_W-1:0] base, input int n);
    @(posedge clk); #1;
    start = 1'b1; base_addr = base; num_pixels = CNT_W'(n);
    clear_stats();
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    check({tag, "_error_pulses"}, 32'(err_cnt), 32'd1);
    check({tag, "_no_reads"}, 32'(cs_cnt), 32'd0);
    check({tag, "_never_busy"}, 32'(busy_cnt), 32'd0);
  endtask

  initial begin
    mem[0] = 32'h44332211;
    mem[1] = 32'h88776655;
    for (int i = 2; i < 16; i++) mem[i] = 32'hA0B0C0D0 + 32'(i * 32'h01010101);
    reset = 1'b1; start = 1'b0; base_addr = '0; num_pixels = '0;
    bus.src_ready = 1'b1; bus.m_readdata = '0;
    outstanding = 0; stall_prev = 1'b0; prev_out = '0;
    clear_stats();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_cs", 32'(bus.m_chipselect), 32'd0);
    check("rst_valid", 32'(bus.src_valid), 32'd0);
    check("rst_sop", 32'(bus.src_sop), 32'd0);
    check("rst_eop", 32'(bus.src_eop), 32'd0);
    check("rst_addr", 32'(bus.m_address), 32'd0);
    check("rst_data", 32'(bus.src_data), 32'd0);
    check("tie_write", 32'(bus.m_write), 32'd0);
    check("tie_be", 32'(bus.m_byteenable), 32'hF);
    check("tie_clken", 32'(bus.m_clken), 32'd1);

    // Basic 8-pixel job, then a start in the cycle right after done.
    start_job(17'd0, 8);
    finish_job("basic", 8, 1'b1);
    start_job(17'd0, 6);
    finish_job("partial", 6, 1'b1);

    // Boundary accept: last two words of memory.
    start_job(17'd124998, 8);
    finish_job("top_of_mem", 8, 1'b1);

    // Single-pixel job: sop and eop together.
    start_job(17'd1, 1);
    finish_job("single", 1, 1'b1);

    // Rejected requests.
    reject_job("rej_zero", 17'd0, 0);
    reject_job("rej_bounds", 17'd124999, 8);

    // Backpressure with a start pulse during the job that must be ignored.
    rand_ready = 1'b1;
    start_job(17'd0, 16);
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    check("busy_at_ignored_start", 32'(busy), 32'd1);
    start = 1'b1; base_addr = 17'd1; num_pixels = CNT_W'(4);
    @(posedge clk); #1;
    start = 1'b0;
    finish_job("backpressure", 16, 1'b0);
    rand_ready = 1'b0;

    // Reset mid-job after three handshakes.
    start_job(17'd0, 8);
    for (int k = 0; k < 50 && hs_cnt < 3; k++) @(negedge clk);
    check("mid_hs_reached", 32'(hs_cnt >= 3), 32'd1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    exp_q.delete();
    addr_q.delete();
    outstanding = 0;
    @(negedge clk);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_valid", 32'(bus.src_valid), 32'd0);
    check("mid_rst_cs", 32'(bus.m_chipselect), 32'd0);
    repeat (3) @(negedge clk);
    start_job(17'd1, 4);
    finish_job("after_reset", 4, 1'b1);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
